instr_mem_loadable: RTL and testbench

Parametrised byte-addressed instruction memory for the 5-stage MIPS pipeline. It replaces the unclocked, event-triggered loader with a clocked valid/ready load port that writes sequential words through an auto-incrementing pointer. Fetch is a registered one-cycle read with alignment, range and unwritten-word checks. It sits between the testbench/boot loader and the IF stage; IF consumes instr and uses instr_valid and addr_err to decide whether to stall or trap.

---
 rtl/instr_mem_loadable.sv | 118 +++++++++++
 tb/tb_instr_mem_loadable.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// Loadable byte-addressed instruction memory: sequential valid/ready load port
// with an auto-incrementing pointer, and a registered one-cycle checked fetch.
module instr_mem_loadable #(
  parameter int INSTR_W     = 32,
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 32,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic                                               clk,
  input  logic                                               reset_n,
  input  logic                                               ld_valid,
  output logic                                               ld_ready,
  input  logic [INSTR_W-1:0]                                 ld_data,
  input  logic                                               ld_clear,
  output logic [$clog2(DEPTH_BYTES/(INSTR_W/8)):0]           ld_count,
  output logic                                               ld_full,
  input  logic                                               rd_en,
  input  logic [ADDR_W-1:0]                                  rd_addr,
  output logic [INSTR_W-1:0]                                 instr,
  output logic                                               instr_valid,
  output logic                                               addr_err
);

  localparam int B     = INSTR_W / 8;
  localparam int WORDS = DEPTH_BYTES / B;
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam int WIDX  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BA_W  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  localparam logic [ADDR_W-1:0] B_A      = ADDR_W'(B);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(DEPTH_BYTES - B);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORDS - 1);

  if ((INSTR_W % 8) != 0 || (DEPTH_BYTES % (INSTR_W / 8)) != 0) begin : g_bad_params
    $error("instr_mem_loadable: INSTR_W must be a multiple of 8 and DEPTH_BYTES a multiple of INSTR_W/8");
  end

  logic [7:0]         mem [DEPTH_BYTES];
  logic [WORDS-1:0]   word_valid;
  logic               accept;
  logic [WIDX-1:0]    wr_idx;
  logic [BA_W-1:0]    wr_base;
  logic [WIDX-1:0]    rd_idx;
  logic [BA_W-1:0]    rd_base;
  logic [INSTR_W-1:0] rd_word;
  logic               misaligned;
  logic               out_of_range;

  // Bit-lane (in bytes) of the word that lives at byte offset k within the word.
  function automatic int unsigned lane_of(input int unsigned k);
    return (BIG_ENDIAN != 0) ? (B - 1 - k) : k;
  endfunction

  assign ld_ready = !ld_full && !ld_clear;
  assign accept   = ld_valid && ld_ready;
  assign wr_idx   = WIDX'(ld_count);
  assign wr_base  = BA_W'(wr_idx) * BA_W'(B);

  // Byte storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k < B; k++) begin
        mem[wr_base + BA_W'(k)] <= ld_data[8*lane_of(k) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_count   <= '0;
      ld_full    <= 1'b0;
      word_valid <= '0;
    end else if (ld_clear) begin
      ld_count   <= '0;
      ld_full    <= 1'b0;
      word_valid <= '0;
    end else if (accept) begin
      word_valid[wr_idx] <= 1'b1;
      ld_count           <= ld_count + CNT_W'(1);
      ld_full            <= (ld_count == LAST_CNT);
    end
  end

  always_comb begin
    misaligned   = (rd_addr % B_A) != '0;
    out_of_range = rd_addr > LAST_A;
    rd_idx       = WIDX'(rd_addr / B_A);
    rd_base      = BA_W'(rd_idx) * BA_W'(B);
    rd_word      = '0;
    for (int unsigned k = 0; k < B; k++) begin
      rd_word[8*lane_of(k) +: 8] = mem[rd_base + BA_W'(k)];
    end
  end

  // Reads sample mem/word_valid before this edge's load/clear lands: read-before-write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else if (rd_en) begin
      if (misaligned || out_of_range) begin
        instr       <= '0;
        instr_valid <= 1'b0;
        addr_err    <= 1'b1;
      end else if (word_valid[rd_idx]) begin
        instr       <= rd_word;
        instr_valid <= 1'b1;
        addr_err    <= 1'b0;
      end else begin
        instr       <= '0;
        instr_valid <= 1'b0;
        addr_err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: a word-level reference model feeds a
// scoreboard queue of expected fetch results, compared one cycle after issue.
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = '0;
  logic        ld_clear = 1'b0;
  logic [6:0]  ld_count;
  logic        ld_full;
  logic        rd_en = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        addr_err;

  instr_mem_loadable #(
    .INSTR_W(32),
    .DEPTH_BYTES(256),
    .ADDR_W(32),
    .BIG_ENDIAN(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_data(ld_data),
    .ld_clear(ld_clear),
    .ld_count(ld_count),
    .ld_full(ld_full),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .instr(instr),
    .instr_valid(instr_valid),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        v;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_e;
  logic [31:0] m_word [64];
  logic [63:0] m_vld;
  int          m_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_fetch(input logic [31:0] a);
    exp_t r;
    r = '0;
    if ((a % 4) != 0 || a > 32'd252) r.e = 1'b1;
    else if (m_vld[a / 4]) begin
      r.instr = m_word[a / 4];
      r.v     = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the model is updated after the fetch expectation is taken.
  task automatic step(input string tag, input logic ldv, input logic [31:0] d,
                      input logic clr, input logic rde, input logic [31:0] a);
    exp_t e;
    ld_valid = ldv; ld_data = d; ld_clear = clr; rd_en = rde; rd_addr = a;
    if (rde) sb.push_back(model_fetch(a));
    if (clr) begin
      m_cnt = 0;
      m_vld = '0;
    end else if (ldv && m_cnt < 64) begin
      m_word[m_cnt] = d;
      m_vld[m_cnt]  = 1'b1;
      m_cnt++;
    end
    tick();
    ld_valid = 1'b0; ld_clear = 1'b0; rd_en = 1'b0;
    if (rde) begin
      e = sb.pop_front();
      chk({tag, ".instr"}, 64'(instr), 64'(e.instr));
      chk({tag, ".valid"}, 64'(instr_valid), 64'(e.v));
      chk({tag, ".err"}, 64'(addr_err), 64'(e.e));
      last_e = e;
    end
  endtask

  task automatic chk_count(input string tag);
    chk({tag, ".count"}, 64'(ld_count), 64'(m_cnt));
    chk({tag, ".full"}, 64'(ld_full), 64'(m_cnt == 64));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_cnt = 0; m_vld = '0; last_e = '0;

    // Reset state
    #1 reset_n = 1'b0;
    repeat (2) tick();
    chk("rst.instr", 64'(instr), 64'h0);
    chk("rst.valid", 64'(instr_valid), 64'h0);
    chk("rst.err", 64'(addr_err), 64'h0);
    chk_count("rst");
    chk("rst.ready", 64'(ld_ready), 64'h1);
    reset_n = 1'b1;
    tick();

    // Two back-to-back loads, then fetches and byte order
    step("ld0", 1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0);
    step("ld1", 1'b1, 32'h2002_0004, 1'b0, 1'b0, 32'h0);
    chk_count("two");
    step("f0", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    chk("f0.const", 64'(instr), 64'h2001_0005);
    step("f4", 1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
    chk("byte0", 64'(dut.mem[0]), 64'h20);
    chk("byte3", 64'(dut.mem[3]), 64'h05);
    step("hold", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("hold.instr", 64'(instr), 64'(last_e.instr));
    chk("hold.valid", 64'(instr_valid), 64'(last_e.v));

    // Error and unloaded-word fetches
    step("f2", 1'b0, 32'h0, 1'b0, 1'b1, 32'h2);
    step("f256", 1'b0, 32'h0, 1'b0, 1'b1, 32'd256);
    step("f4ok", 1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
    step("fFFFC", 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("f8", 1'b0, 32'h0, 1'b0, 1'b1, 32'h8);
    step("f252u", 1'b0, 32'h0, 1'b0, 1'b1, 32'd252);

    // Fill to capacity; full must not rise early
    for (int i = 2; i < 63; i++) step("fill", 1'b1, 32'h1000_0000 + 32'(i) * 32'h0101, 1'b0, 1'b0, 32'h0);
    chk_count("w63");
    step("ld63", 1'b1, 32'hCAFE_0063, 1'b0, 1'b0, 32'h0);
    chk_count("full");
    chk("full.ready", 64'(ld_ready), 64'h0);
    step("ld64", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    chk_count("over");
    step("ff0", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    step("ff252", 1'b0, 32'h0, 1'b0, 1'b1, 32'd252);
    chk("ff252.const", 64'(instr), 64'hCAFE_0063);
    step("ff256", 1'b0, 32'h0, 1'b0, 1'b1, 32'd256);

    // Clear from full, load 3, clear again with valid high and same-cycle fetch
    step("clr1", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk_count("clr1");
    for (int i = 0; i < 3; i++) step("ld3", 1'b1, 32'h3000_0000 + 32'(i), 1'b0, 1'b0, 32'h0);
    chk_count("three");
    ld_valid = 1'b1; ld_clear = 1'b1; ld_data = 32'h7777_7777;
    #1;
    chk("clr.ready", 64'(ld_ready), 64'h0);
    step("clr2", 1'b1, 32'h7777_7777, 1'b1, 1'b1, 32'h0);
    chk_count("clr2");
    step("pc0", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    step("rl", 1'b1, 32'h0800_0002, 1'b0, 1'b0, 32'h0);
    step("rl0", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    step("rl4", 1'b0, 32'h0, 1'b0, 1'b1, 32'h4);

    // Same-cycle load and fetch of word 0 on a freshly cleared memory
    step("clr3", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step("rbw", 1'b1, 32'h0022_1820, 1'b0, 1'b1, 32'h0);
    step("rbw2", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    chk("rbw2.const", 64'(instr), 64'h0022_1820);

    // Asynchronous reset in the middle of a load burst
    step("burst", 1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0);
    ld_valid = 1'b1; ld_data = 32'hAAAA_0002;
    #3 reset_n = 1'b0;
    #1;
    chk("arst.instr", 64'(instr), 64'h0);
    chk("arst.valid", 64'(instr_valid), 64'h0);
    chk("arst.count", 64'(ld_count), 64'h0);
    chk("arst.full", 64'(ld_full), 64'h0);
    ld_valid = 1'b0;
    m_cnt = 0; m_vld = '0;
    tick();
    reset_n = 1'b1;
    tick();
    chk_count("post");
    step("post0", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
